// File: rtl/ad_nios_counter_chain.sv
// ---------------------------------------------------------------------------
// ad_nios_counter_chain
//
// Chainable loadable counter slice. One WIDTH-bit register counts up or down.
// At the terminal count it either wraps (modulo) or holds (saturate). It also
// has a synchronous clear and load, and a combinational carry chain
// (cascin -> cascout) so that several slices can form a wider counter that
// advances on a single edge. A registered equality compare against
// cmp_value is also provided.
//
// Parameters
//   WIDTH        counter width in bits (1..32)
//   MAX_VALUE    terminal count in up mode (<= 2^WIDTH-1)
//   RESET_VALUE  value of q after reset
//   SATURATE     0 = wrap at terminal count, 1 = hold at terminal count
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   reset_n    in   asynchronous active-low reset
//   ena        in   clock enable; low holds q and forces wrap to 0
//   cascin     in   count enable from the previous slice (tie 1 on first)
//   sclr       in   synchronous clear to 0 (highest priority)
//   sload      in   synchronous load of sdata
//   sdata      in   load value
//   updown     in   1 = count up, 0 = count down
//   cmp_value  in   compare reference
//   q          out  registered counter value
//   tc         out  terminal-count flag, combinational from q and updown
//   cascout    out  cascin & tc, feeds cascin of the next slice
//   wrap       out  one-cycle registered pulse after a wrap/saturate event
//   cmp_match  out  registered (q == cmp_value), lags q by one cycle
// ---------------------------------------------------------------------------
module ad_nios_counter_chain #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ena,
    input  logic             cascin,
    input  logic             sclr,
    input  logic             sload,
    input  logic [WIDTH-1:0] sdata,
    input  logic             updown,
    input  logic [WIDTH-1:0] cmp_value,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             cascout,
    output logic             wrap,
    output logic             cmp_match
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("ad_nios_counter_chain: WIDTH must be in 1..32");
    end

    // One counting step. The MSB of the result flags a terminal event
    // (wrap or saturate). In up mode a value above MAX_VALUE, which can
    // only arrive through sload, is treated as terminal as well. The
    // increment cannot overflow, because it is only taken when
    // cur < MAX_VALUE <= 2^WIDTH-1.
    function automatic logic [WIDTH:0] count_step(
        input logic [WIDTH-1:0] cur,
        input logic             up
    );
        logic [WIDTH-1:0] nxt;
        logic             ev;
        nxt = cur;
        ev  = 1'b0;
        if (up) begin
            if (cur < MAX_VALUE) begin
                nxt = cur + ONE;
            end else begin
                ev  = 1'b1;
                nxt = SATURATE ? MAX_VALUE : ZERO;
            end
        end else begin
            if (cur != ZERO) begin
                nxt = cur - ONE;
            end else begin
                ev  = 1'b1;
                nxt = SATURATE ? ZERO : MAX_VALUE;
            end
        end
        return {ev, nxt};
    endfunction

    function automatic logic terminal(
        input logic [WIDTH-1:0] cur,
        input logic             up
    );
        return up ? (cur >= MAX_VALUE) : (cur == ZERO);
    endfunction

    logic [WIDTH-1:0] q_p1;
    logic             wrap_p1;
    logic             cmp_match_p1;

    logic [WIDTH:0]   step_p0;
    logic [WIDTH-1:0] q_nxt_p0;
    logic             wrap_nxt_p0;

    // Stage p0: next-state selection, priority sclr > sload > count
    always_comb begin
        step_p0     = count_step(q_p1, updown);
        q_nxt_p0    = q_p1;
        wrap_nxt_p0 = 1'b0;
        if (ena) begin
            if (sclr) begin
                q_nxt_p0 = ZERO;
            end else if (sload) begin
                q_nxt_p0 = sdata;
            end else if (cascin) begin
                q_nxt_p0    = step_p0[WIDTH-1:0];
                wrap_nxt_p0 = step_p0[WIDTH];
            end
        end
    end

    // Stage p1: registered counter, wrap pulse and compare.
    // The compare is clocked regardless of ena.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_p1         <= RESET_VALUE;
            wrap_p1      <= 1'b0;
            cmp_match_p1 <= 1'b0;
        end else begin
            q_p1         <= q_nxt_p0;
            wrap_p1      <= wrap_nxt_p0;
            cmp_match_p1 <= (q_p1 == cmp_value);
        end
    end

    assign q         = q_p1;
    assign wrap      = wrap_p1;
    assign cmp_match = cmp_match_p1;

    // tc and cascout stay combinational so that a chain of slices carries
    // through in the same cycle.
    assign tc      = terminal(q_p1, updown);
    assign cascout = cascin & tc;

endmodule
